// File: rtl/ifetch_pc_unit.sv
// Instruction-fetch PC unit: next-PC selection, BRAM addressing and ecall halt/resume.
// Optional taken-redirect counter is built only when IFETCH_REDIRECT_COUNT_EN is defined.
module ifetch_pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  branch,
    input  logic                  do_branch,
    input  logic                  jal,
    input  logic                  jalr,
    input  logic [31:0]           imm32,
    input  logic [31:0]           alu_result,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_rdata,
    output logic [31:0]           instruction,
    output logic [31:0]           pc,
    output logic [31:0]           pc_plus4,
    output logic                  instr_valid,
    output logic                  halted,
    output logic                  misalign_err,
    output logic [31:0]           redirect_count
);

    typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_resume_q;
    logic        r_misalign;
    logic        r_halted;
    logic        r_instr_valid;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_rel_target;
    logic [31:0] w_next_pc;
    logic        w_run_go;
    logic        w_halt_take;
    logic        w_redirect;
    logic        w_target_bit1;

    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_rel_target  = r_pc + imm32;
    assign w_run_go      = (r_state == ST_RUN) && !stall;
    assign w_halt_take   = w_run_go && halt_req;
    assign w_redirect    = w_run_go && !halt_req && (jalr || jal || (branch && do_branch));
    assign w_target_bit1 = jalr ? alu_result[1] : w_rel_target[1];

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (rst) begin
            w_next_pc = RESET_PC;
        end else if ((r_state == ST_HALT) || stall) begin
            w_next_pc = r_pc;
        end else if (halt_req) begin
            w_next_pc = w_pc_plus4;
        end else if (jalr) begin
            w_next_pc = alu_result & 32'hFFFF_FFFC;
        end else if (jal || (branch && do_branch)) begin
            w_next_pc = w_rel_target & 32'hFFFF_FFFC;
        end
    end

    // The BRAM registers this address, so it must already be next cycle's PC.
    assign imem_addr = w_next_pc[ADDR_WIDTH+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_resume_q    <= 1'b0;
            r_misalign    <= 1'b0;
            r_halted      <= 1'b0;
            r_instr_valid <= 1'b1;
        end else begin
            r_pc       <= w_next_pc;
            r_resume_q <= resume;
            if (w_redirect && w_target_bit1) begin
                r_misalign <= 1'b1;
            end
            case (r_state)
                ST_RUN: begin
                    if (w_halt_take) begin
                        r_state       <= ST_HALT;
                        r_halted      <= 1'b1;
                        r_instr_valid <= 1'b0;
                    end
                end
                ST_HALT: begin
                    // Only a fresh press resumes; a button held across the halt is ignored.
                    if (resume && !r_resume_q) begin
                        r_state       <= ST_RUN;
                        r_halted      <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= ST_RUN;
                    r_halted      <= 1'b0;
                    r_instr_valid <= 1'b1;
                end
            endcase
        end
    end

`ifdef IFETCH_REDIRECT_COUNT_EN
    logic [31:0] r_redirect_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_count <= 32'd0;
        end else if (w_redirect && (r_redirect_count != 32'hFFFF_FFFF)) begin
            r_redirect_count <= r_redirect_count + 32'd1;
        end
    end

    assign redirect_count = r_redirect_count;
`else
    assign redirect_count = 32'd0;
`endif

    assign instruction  = imem_rdata;
    assign pc           = r_pc;
    assign pc_plus4     = w_pc_plus4;
    assign instr_valid  = r_instr_valid;
    assign halted       = r_halted;
    assign misalign_err = r_misalign;

endmodule

// File: tb/tb_ifetch_pc_unit.sv
// Testbench for ifetch_pc_unit: behavioural fetch model checked every cycle plus directed literal checks.
module tb_ifetch_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          AW       = 14;

    logic          clk = 1'b0;
    logic          rst, stall, branch, do_branch, jal, jalr, halt_req, resume;
    logic [31:0]   imm32, alu_result, imem_rdata;
    logic [AW-1:0] imem_addr;
    logic [31:0]   instruction, pc, pc_plus4, redirect_count;
    logic          instr_valid, halted, misalign_err;

    int checks   = 0;
    int failures = 0;

    ifetch_pc_unit #(.RESET_PC(RESET_PC), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch), .do_branch(do_branch),
        .jal(jal), .jalr(jalr), .imm32(imm32), .alu_result(alu_result),
        .halt_req(halt_req), .resume(resume), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instruction(instruction), .pc(pc),
        .pc_plus4(pc_plus4), .instr_valid(instr_valid), .halted(halted),
        .misalign_err(misalign_err), .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    // Instruction BRAM with registered read; each word is tagged with its index.
    logic [31:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA000_0000 | i;
        mem[0] = 32'h0050_0093;
    end
    always @(posedge clk) imem_rdata <= mem[imem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Architectural model: pc, run/halt, sticky error, redirect count.
    logic        m_active = 1'b0;
    logic [31:0] m_pc, m_cnt;
    logic        m_halted, m_err, m_rq;
    wire  [31:0] m_tgt = jalr ? alu_result : (m_pc + imm32);

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b1;
            m_pc     <= RESET_PC;
            m_halted <= 1'b0;
            m_err    <= 1'b0;
            m_cnt    <= 32'd0;
            m_rq     <= 1'b0;
        end else if (m_active) begin
            m_rq <= resume;
            if (m_halted) begin
                if (resume && !m_rq) m_halted <= 1'b0;
            end else if (!stall) begin
                if (halt_req) begin
                    m_pc     <= m_pc + 32'd4;
                    m_halted <= 1'b1;
                end else if (jalr || jal || (branch && do_branch)) begin
                    m_pc <= {m_tgt[31:2], 2'b00};
                    if (m_tgt[1]) m_err <= 1'b1;
`ifdef IFETCH_REDIRECT_COUNT_EN
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
`endif
                end else begin
                    m_pc <= m_pc + 32'd4;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_active) begin
            if (rst) chk("imem_addr_rst", 32'(imem_addr), 32'(RESET_PC[AW+1:2]));
            chk("pc", pc, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("halted", 32'(halted), 32'(m_halted));
            chk("instr_valid", 32'(instr_valid), 32'(!m_halted));
            chk("misalign_err", 32'(misalign_err), 32'(m_err));
            chk("redirect_count", redirect_count, m_cnt);
            if (!m_halted) chk("instruction", instruction, mem[m_pc[AW+1:2]]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        stall = 0; branch = 0; do_branch = 0; jal = 0; jalr = 0;
        halt_req = 0; imm32 = 0; alu_result = 0;
    endtask

    logic [31:0] cnt_before;

    initial begin
        clr();
        resume = 0;
        rst = 1;
        tick(); tick();
        rst = 0;
        chk("L_reset_pc", pc, 32'h0);
        chk("L_reset_instr", instruction, 32'h0050_0093);
        chk("L_reset_valid", 32'(instr_valid), 32'd1);
        chk("L_reset_cnt", redirect_count, 32'd0);
        tick();
        chk("L_seq_pc", pc, 32'h4);
        tick(); tick(); tick();
        chk("L_at_10", pc, 32'h10);

        branch = 1; do_branch = 1; imm32 = 32'hFFFF_FFF8; tick(); clr();
        chk("L_br_taken", pc, 32'h8);
        jal = 1; imm32 = 32'h8; tick(); clr();
        branch = 1; do_branch = 0; tick(); clr();
        chk("L_br_not_taken", pc, 32'h14);
        jal = 1; imm32 = 32'hFFFF_FFFC; tick(); clr();
        chk("L_jal_back", pc, 32'h10);
        do_branch = 1; tick(); clr();
        chk("L_dobr_no_branch", pc, 32'h14);

        jalr = 1; alu_result = 32'h0000_0123; tick(); clr();
        chk("L_jalr_pc", pc, 32'h120);
        chk("L_jalr_err", 32'(misalign_err), 32'd1);
        tick(); tick();
        chk("L_err_sticky", 32'(misalign_err), 32'd1);

        jalr = 1; alu_result = 32'h20; tick(); clr();
        cnt_before = m_cnt;
        stall = 1; jal = 1; imm32 = 32'h100;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("L_stall_pc", pc, 32'h20);
            chk("L_stall_instr", instruction, 32'hA000_0008);
        end
        stall = 0; tick(); clr();
        chk("L_stall_release", pc, 32'h120);
`ifdef IFETCH_REDIRECT_COUNT_EN
        chk("L_cnt_plus1", redirect_count, cnt_before + 32'd1);
`else
        chk("L_cnt_zero", redirect_count, 32'd0);
`endif

        jalr = 1; alu_result = 32'h40; resume = 1; tick(); clr();
        halt_req = 1; tick(); clr();
        chk("L_halt", 32'(halted), 32'd1);
        chk("L_halt_valid", 32'(instr_valid), 32'd0);
        chk("L_halt_pc", pc, 32'h44);
        tick(); tick();
        chk("L_held_no_resume", 32'(halted), 32'd1);
        resume = 0; tick();
        resume = 1; tick();
        chk("L_resumed", 32'(halted), 32'd0);
        chk("L_resume_instr", instruction, 32'hA000_0011);
        tick();
        chk("L_after_resume", pc, 32'h48);
        resume = 0;

        stall = 1; halt_req = 1; tick();
        chk("L_halt_stalled", 32'(halted), 32'd0);
        stall = 0; tick(); clr();
        chk("L_halt_late", 32'(halted), 32'd1);
        chk("L_halt_late_pc", pc, 32'h4C);
        resume = 1; tick(); resume = 0; tick();
        chk("L_resume2_pc", pc, 32'h50);

        jalr = 1; alu_result = 32'h7C; tick(); clr();
        halt_req = 1; jal = 1; imm32 = 32'h200; tick(); clr();
        chk("L_halt_beats_jal", pc, 32'h80);
        rst = 1; tick();
        chk("L_rst_halt_pc", pc, RESET_PC);
        chk("L_rst_halt_halted", 32'(halted), 32'd0);
        chk("L_rst_halt_cnt", redirect_count, 32'd0);
        rst = 0;

        jal = 1; imm32 = 32'h1; tick(); clr();
        chk("L_bit0_align", pc, 32'h0);
        chk("L_bit0_noerr", 32'(misalign_err), 32'd0);

        jalr = 1; alu_result = 32'hFFFF_FFFC; tick(); clr();
        chk("L_alias_instr", instruction, 32'hA000_3FFF);
        tick();
        chk("L_wrap", pc, 32'h0);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
